// File: rtl/calc_param.sv
// calc_param: keypad calculator core. Collects two unsigned decimal operands
// from 4-bit key codes, runs add / subtract / iterative shift-add multiply,
// traps overflow and underflow into an error state, and serialises the shown
// value to the display controller one decimal digit per cycle, LSD first.
module calc_param #(
  parameter int DIGITS = 8,
  parameter int WIDTH  = 27,
  parameter int POSW   = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0]      cmd,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  output logic [1:0]      status,
  output logic [3:0]      data,
  output logic [POSW-1:0] pos,
  output logic            data_valid,
  output logic [2:0]      state
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < n; i++) v = v * 64'd10;
    return v;
  endfunction

  // Largest displayable value and the entry bound beyond which a new digit
  // would no longer fit on the display.
  localparam logic [WIDTH-1:0]   MAX_VAL   = WIDTH'(pow10(DIGITS) - 64'd1);
  localparam logic [WIDTH:0]     MAX_SUM   = (WIDTH+1)'(pow10(DIGITS) - 64'd1);
  localparam logic [2*WIDTH-1:0] MAX_PROD  = (2*WIDTH)'(pow10(DIGITS) - 64'd1);
  localparam logic [WIDTH-1:0]   ENTRY_LIM = WIDTH'(pow10(DIGITS-1));
  localparam int                 CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_MUL = 4'd12;
  localparam logic [3:0] K_CLR = 4'd13;
  localparam logic [3:0] K_EQ  = 4'd14;
  localparam logic [3:0] K_BS  = 4'd15;

  localparam logic [1:0] ST_ERROR = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_PRINT = 2'b11;

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_EXEC    = 3'd2,
    S_ERROR   = 3'd3
  } fsm_t;

  function automatic logic [WIDTH-1:0] div10(input logic [WIDTH-1:0] v);
    return v / WIDTH'(10);
  endfunction

  function automatic logic [3:0] mod10(input logic [WIDTH-1:0] v);
    return 4'(v % WIDTH'(10));
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                input logic [3:0]       d);
    return (v << 3) + (v << 1) + WIDTH'(d);
  endfunction

  fsm_t               fsm;
  logic [WIDTH-1:0]   acc, rega, regb, shadow;
  logic [3:0]         op;
  logic [2*WIDTH-1:0] mcand, prod;
  logic [CW-1:0]      mcnt;

  logic               accept;
  fsm_t               k_fsm;
  logic [WIDTH-1:0]   k_acc, k_rega, k_regb;
  logic [3:0]         k_op;
  logic               k_print, k_exec;
  logic               x_done, x_err;
  logic [WIDTH-1:0]   x_res;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_n;
  logic               pr_start;
  logic [WIDTH-1:0]   pr_val;

  assign cmd_ready = (status == ST_READY) || (status == ST_ERROR);
  assign accept    = cmd_valid && cmd_ready;
  assign state     = fsm;
  assign sum       = {1'b0, rega} + {1'b0, regb};
  assign prod_n    = prod + (regb[0] ? mcand : '0);

  // Decode an accepted key into its effect on the operand registers.
  always_comb begin
    k_fsm   = fsm;
    k_acc   = acc;
    k_rega  = rega;
    k_regb  = regb;
    k_op    = op;
    k_print = 1'b0;
    k_exec  = 1'b0;
    if (accept) begin
      if (cmd == K_CLR) begin
        k_acc   = '0;
        k_rega  = '0;
        k_regb  = '0;
        k_op    = '0;
        k_fsm   = S_ENTER_A;
        k_print = 1'b1;
      end else if (fsm == S_ERROR) begin
        k_print = 1'b0;
      end else if (cmd <= 4'd9) begin
        if (acc < ENTRY_LIM) begin
          k_acc   = shift_in(acc, cmd);
          k_print = 1'b1;
        end
      end else if (cmd == K_BS) begin
        k_acc   = div10(acc);
        k_print = 1'b1;
      end else if (cmd == K_ADD || cmd == K_SUB || cmd == K_MUL) begin
        k_op = cmd;
        if (fsm == S_ENTER_A) begin
          k_rega  = acc;
          k_acc   = '0;
          k_fsm   = S_ENTER_B;
          k_print = 1'b1;
        end
      end else if (cmd == K_EQ) begin
        if (fsm == S_ENTER_B) begin
          k_regb = acc;
          k_fsm  = S_EXEC;
          k_exec = 1'b1;
        end
      end
    end
  end

  // Decide the operation outcome; multiply only finishes on its last step.
  always_comb begin
    x_done = 1'b0;
    x_err  = 1'b0;
    x_res  = '0;
    if (fsm == S_EXEC) begin
      case (op)
        K_ADD: begin
          x_done = 1'b1;
          x_err  = sum > MAX_SUM;
          x_res  = sum[WIDTH-1:0];
        end
        K_SUB: begin
          x_done = 1'b1;
          x_err  = rega < regb;
          x_res  = rega - regb;
        end
        K_MUL: begin
          if (mcnt == CW'(WIDTH-1)) begin
            x_done = 1'b1;
            x_err  = prod_n > MAX_PROD;
            x_res  = prod_n[WIDTH-1:0];
          end
        end
        default: begin
          x_done = 1'b1;
          x_err  = 1'b1;
        end
      endcase
    end
  end

  assign pr_start = k_print || (x_done && !x_err);
  assign pr_val   = x_done ? x_res : k_acc;

  // Control FSM: operand registers, shift-add multiplier and status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm    <= S_ENTER_A;
      status <= ST_READY;
      acc    <= '0;
      rega   <= '0;
      regb   <= '0;
      op     <= '0;
      mcand  <= '0;
      prod   <= '0;
      mcnt   <= '0;
    end else begin
      fsm  <= k_fsm;
      acc  <= k_acc;
      rega <= k_rega;
      regb <= k_regb;
      op   <= k_op;
      if (k_exec) begin
        prod  <= '0;
        mcand <= {{WIDTH{1'b0}}, rega};
        mcnt  <= '0;
      end
      if (fsm == S_EXEC) begin
        if (x_done) begin
          if (x_err) begin
            fsm <= S_ERROR;
          end else begin
            acc  <= x_res;
            rega <= '0;
            regb <= '0;
            fsm  <= S_ENTER_A;
          end
        end else begin
          prod  <= prod_n;
          regb  <= regb >> 1;
          mcand <= mcand << 1;
          mcnt  <= mcnt + CW'(1);
        end
      end
      if (x_done && x_err)
        status <= ST_ERROR;
      else if (pr_start)
        status <= ST_PRINT;
      else if (k_exec)
        status <= ST_BUSY;
      else if (status == ST_PRINT && pos == POSW'(DIGITS-1))
        status <= ST_READY;
    end
  end

  // Print serialiser: emits DIGITS decimal digits, least significant first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data       <= '0;
      pos        <= '0;
      data_valid <= 1'b0;
      shadow     <= '0;
    end else if (pr_start) begin
      data       <= mod10(pr_val);
      shadow     <= div10(pr_val);
      pos        <= '0;
      data_valid <= 1'b1;
    end else if (data_valid) begin
      if (pos == POSW'(DIGITS-1)) begin
        data_valid <= 1'b0;
        pos        <= '0;
        data       <= '0;
      end else begin
        data   <= mod10(shadow);
        shadow <= div10(shadow);
        pos    <= pos + POSW'(1);
      end
    end
  end

  // MAX_VAL documents the displayable range used by the sum/product bounds.
  logic unused_max;
  assign unused_max = ^MAX_VAL;

endmodule

// File: doc/calc_param.md
# calc_param

Parametrised successor to the team's keypad calculator core. Accepts 4-bit key codes through a valid/ready handshake, accumulates two unsigned decimal operands, and executes add, subtract or multiply. Multiply is an iterative shift-add. The block detects overflow and underflow into an error state. It serialises the displayed value one decimal digit per cycle to the display controller. It sits between the keypad decoder and the multi-digit 7-segment display controller.

## Interface
- DIGITS, 8: number of display digits; operands and results are limited to 0 .. 10^DIGITS-1.
- WIDTH, 27: binary width of operand/result registers; must satisfy 10^DIGITS-1 < 2^WIDTH.
- POSW, 4: width of pos; must satisfy 2^POSW >= DIGITS.
- clock, in, 1: single clock; all logic on rising edge.
- reset, in, 1: asynchronous, active-high; clears all state.
- cmd, in, 4: key code. Codes are:
  - 0-9: digit.
  - 10: '+'.
  - 11: '-'.
  - 12: '*'.
  - 13: clear.
  - 14: '='.
  - 15: backspace.
- cmd_valid, in, 1: cmd is presented this cycle.
- cmd_ready, out, 1: high when status == READY or ERROR; a key is accepted on a cycle with cmd_valid && cmd_ready.
- status, out, 2: 00 ERROR, 01 BUSY (computing), 10 READY, 11 PRINTING.
- data, out, 4: BCD digit being printed.
- pos, out, POSW: digit position of data; 0 is the least significant digit.
- data_valid, out, 1: data/pos valid this cycle.
- state, out, 3: FSM state for debug. Values are:
  - 0: ENTER_A.
  - 1: ENTER_B.
  - 2: EXEC.
  - 3: ERROR.

## Operation
- Registers: acc (the value being entered or shown), regA, regB, op, and a print shadow shift register.
- Digit d, accepted:
  - If acc < 10^(DIGITS-1), then acc <= acc*10 + d and a print is started.
  - Otherwise the key is dropped silently: no print, status stays READY.
- Backspace, accepted: acc <= acc/10, then print.
- ENTER_A:
  - Operator key (10/11/12): regA <= acc, op <= cmd, acc <= 0, go to ENTER_B, print (all zeros).
  - '=': ignored.
- ENTER_B:
  - Digits and backspace: as above.
  - '=': regB <= acc, go to EXEC, status BUSY.
  - Operator key: replaces op without printing.
- EXEC, add:
  - Result r = regA + regB is computed in 1 cycle.
  - If r > 10^DIGITS-1, go to ERROR.
- EXEC, subtract:
  - If regA < regB, go to ERROR.
  - Otherwise r = regA - regB.
- EXEC, multiply:
  - Shift-add over exactly WIDTH cycles into a 2*WIDTH-bit product: one multiplier bit per cycle, LSB first.
  - If the product > 10^DIGITS-1, go to ERROR.
- EXEC success: acc <= r, regA/regB <= 0, go to ENTER_A, print r. This allows chaining: the next operator uses r as A.
- ERROR:
  - status = 00, no printing, data_valid = 0.
  - Only clear (13) is acted on; all other accepted keys are dropped.
- Clear, accepted in any state:
  - acc, regA, regB and op <= 0.
  - Go to ENTER_A and print zeros.
- Print:
  - The shadow register is loaded with acc.
  - Each cycle: data <= shadow % 10, shadow <= shadow / 10, pos increments.
  - Exactly DIGITS digits are printed, leading zeros included.
  - After the last digit: status READY.

## Timing
- Reset values:
  - state ENTER_A, status 10, cmd_ready 1, data 0, pos 0, data_valid 0.
  - acc, regA, regB, op and shadow all 0.
- Print after a key accepted at edge N:
  - status = 11 and cmd_ready = 0 from edge N+1.
  - data_valid is high for cycles N+1 .. N+DIGITS, with pos = 0 .. DIGITS-1.
  - At edge N+DIGITS+1: status = 10, pos = 0, data_valid = 0.
- '=' accepted at edge N:
  - status = 01 from N+1.
  - Add/sub: result is decided at edge N+2; printing starts in the following cycle.
  - Multiply: result is decided at edge N+1+WIDTH.
  - Error: status = 00 from the decision edge.
- cmd_valid is ignored while cmd_ready = 0. Upstream holds the key until it is accepted.
- Dropped keys (full entry, '=' in ENTER_A, non-clear key in ERROR) consume the handshake but produce no print.
- Reset asserted mid-multiply or mid-print aborts immediately: outputs take reset values asynchronously.

## Test plan
- Defaults, from reset:
  - Keys 1,2,+,3,4,= -> each key prints DIGITS digits.
  - Final print is 6,4,0,0,0,0,0,0 at pos 0..7.
  - state returns to 0, status 10.
- Keys 7,-,9,= -> status 00 two cycles after '=' accepted. No print.
  - Key 5 is dropped with no print.
  - Key 13 -> prints eight zeros, status 10.
- Keys 9,9,9,9,*,9,9,9,9,= -> status 01 for 27 cycles.
  - Then prints 1,0,0,0,8,9,9,9 (99980001).
- Enter 99999999 -> a ninth digit is dropped (no print, acc unchanged).
  - Keys +,1,= -> ERROR.
- Keys 4,5,6,backspace -> last print 5,4,0,...
  - Keys *,3,= -> 135.
  - Chained keys +,5,= -> 140.
- Reset asserted during multiply EXEC cycle 10:
  - Outputs immediately take reset values.
  - Keys 2,+,2,= -> 4.
